// File: rtl/vga_capture_if.sv
// Video input bundle from the VGA timing generator into the board capture block.
interface vga_capture_if;
   logic hsync;
   logic vsync;
   logic in_display;
   logic vga_r;
   logic vga_g;
   logic vga_b;

   modport master (output hsync, vsync, in_display, vga_r, vga_g, vga_b);
   modport slave  (input  hsync, vsync, in_display, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_capture.sv
// vga_capture: samples the centre pixel of each of the 10x20 board cells from a
// VGA pixel stream and commits a full grid once per complete frame.
// Optional feature macro: CAPTURE_CHECKSUM_EN (mod-256 sum of the committed grid).
module vga_capture #(
   parameter int unsigned BOARD_X0 = 240,
   parameter int unsigned BOARD_Y0 = 80,
   parameter int unsigned CELL_PX  = 16
) (
   input  logic         clock,
   input  logic         reset,
   vga_capture_if.slave vid,
   input  logic [3:0]   rd_col,
   input  logic [4:0]   rd_row,
   output logic [2:0]   rd_color,
   output logic         frame_valid,
   output logic [10:0]  frame_count,
   output logic         sync_error,
   output logic [7:0]   frame_checksum
);

   localparam int unsigned COLS  = 10;
   localparam int unsigned ROWS  = 20;
   localparam int unsigned CELLS = COLS * ROWS;
   localparam int unsigned CW    = 3;
   localparam int unsigned PW    = 10;
   localparam int unsigned IW    = 8;
   localparam int unsigned FW    = 11;
   localparam int unsigned SH    = $clog2(CELL_PX);
   localparam int unsigned HALF  = CELL_PX / 2;

   localparam logic [PW-1:0] X_LO  = PW'(BOARD_X0);
   localparam logic [PW-1:0] X_HI  = PW'(BOARD_X0 + COLS * CELL_PX);
   localparam logic [PW-1:0] Y_LO  = PW'(BOARD_Y0);
   localparam logic [PW-1:0] Y_HI  = PW'(BOARD_Y0 + ROWS * CELL_PX);
   localparam logic [PW-1:0] P_MAX = '1;

   typedef enum logic [0:0] {IDLE, CAPTURE} state_t;

   state_t          state_q, state_d;
   logic            hs_q, vs_q;
   logic            hs_fall_c, vs_fall_c;
   logic [PW-1:0]   x_q, x_d, y_q, y_d;
   logic [PW-1:0]   x_off_c, y_off_c;
   logic            line_act_q, line_act_d;
   logic [CELLS-1:0] flags_q;
   logic [CW-1:0]   cap_q  [CELLS];
   logic [CW-1:0]   grid_q [CELLS];
   logic [CW-1:0]   pix_c;
   logic            hit_c, sample_c, commit_c, error_c;
   logic [IW-1:0]   wr_idx_c, rd_idx_c;
   logic            frame_valid_q, sync_error_q;
   logic [FW-1:0]   frame_count_q;

   assign pix_c     = {vid.vga_r, vid.vga_g, vid.vga_b};
   assign hs_fall_c = hs_q & ~vid.hsync;
   assign vs_fall_c = vs_q & ~vid.vsync;

   // Pixel/line position counters; a line only advances y if it carried display pixels
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      line_act_d = line_act_q;
      if (hs_fall_c)
         x_d = '0;
      else if (vid.in_display && x_q != P_MAX)
         x_d = x_q + PW'(1);
      if (vs_fall_c)
         y_d = '0;
      else if (hs_fall_c && line_act_q && y_q != P_MAX)
         y_d = y_q + PW'(1);
      if (hs_fall_c || vs_fall_c)
         line_act_d = 1'b0;
      else if (vid.in_display)
         line_act_d = 1'b1;
   end

   // Cell-centre hit detection and buffer index
   assign x_off_c  = x_q - X_LO;
   assign y_off_c  = y_q - Y_LO;
   assign hit_c    = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI)
                     && (x_off_c[SH-1:0] == SH'(HALF)) && (y_off_c[SH-1:0] == SH'(HALF));
   assign wr_idx_c = IW'(y_off_c >> SH) * IW'(COLS) + IW'(x_off_c >> SH);
   assign sample_c = (state_q == CAPTURE) && vid.in_display && hit_c;

   // Next state and commit/error decision at each vsync fall
   always_comb begin
      state_d  = state_q;
      commit_c = 1'b0;
      error_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (vs_fall_c) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (vs_fall_c) begin
               if (&flags_q) commit_c = 1'b1;
               else          error_c  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Sync edges, counters, captured flags, committed grid and status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_act_q    <= 1'b0;
         flags_q       <= '0;
         frame_valid_q <= 1'b0;
         sync_error_q  <= 1'b0;
         frame_count_q <= '0;
         for (int i = 0; i < int'(CELLS); i++) grid_q[i] <= '0;
      end else begin
         hs_q          <= vid.hsync;
         vs_q          <= vid.vsync;
         x_q           <= x_d;
         y_q           <= y_d;
         line_act_q    <= line_act_d;
         frame_valid_q <= commit_c;
         sync_error_q  <= error_c;
         if (vs_fall_c)
            flags_q <= '0;
         else if (sample_c)
            flags_q[wr_idx_c] <= 1'b1;
         if (commit_c) begin
            frame_count_q <= frame_count_q + FW'(1);
            grid_q        <= cap_q;
         end
      end
   end

   // Capture buffer; contents only matter once every flag is set, so no reset
   always_ff @(posedge clock) begin
      if (sample_c) cap_q[wr_idx_c] <= pix_c;
   end

`ifdef CAPTURE_CHECKSUM_EN
   logic [7:0] sum_c, checksum_q;

   // Mod-256 sum of the frame about to be committed
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(CELLS); i++) sum_c = sum_c + 8'(cap_q[i]);
   end

   // Checksum register follows the committed grid
   always_ff @(posedge clock) begin
      if (reset)         checksum_q <= '0;
      else if (commit_c) checksum_q <= sum_c;
   end

   assign frame_checksum = checksum_q;
`else
   assign frame_checksum = 8'd0;
`endif

   assign rd_idx_c    = IW'(rd_row) * IW'(COLS) + IW'(rd_col);
   assign rd_color    = (rd_col < 4'd10 && rd_row < 5'd20) ? grid_q[rd_idx_c] : '0;
   assign frame_valid = frame_valid_q;
   assign sync_error  = sync_error_q;
   assign frame_count = frame_count_q;

endmodule
